// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates a single fixed-latency memory port between the
// fetch stage (read-only) and the memory stage (read/write). One access is in
// flight at a time. Contention is resolved round-robin. Read data is registered
// and presented with a one-cycle ready pulse to the requester that owned the
// access.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   if_req/if_addr        fetch read request and byte address
//   if_rdata/if_ready     fetch read data and completion pulse
//   d_req/d_we/d_addr     data request, write enable and byte address
//   d_wdata               data write data
//   d_rdata/d_ready       data read data and completion pulse
//   mem_en/mem_we         memory strobe (one cycle per access) and write enable
//   mem_addr/mem_wdata    word-aligned memory address and write data
//   mem_rdata             memory read data, valid LATENCY cycles after mem_en
//   busy                  high whenever an access is in progress
module mem_port_arbiter #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam logic [3:0]        CntLoad  = 4'(LATENCY - 1);
  localparam logic [ADDR_W-1:0] WordMask = {{(ADDR_W - 2){1'b1}}, 2'b00};

  state_e      state_q;
  logic [3:0]  cnt_q;
  // Owner / last-grant encoding: 1 = data, 0 = fetch.
  logic        last_grant_q;
  logic        owner_q;
  logic        grant_d;

  // Data wins when it is the only requester, or when both contend and fetch
  // had the previous grant.
  always_comb begin
    grant_d = d_req & (~if_req | ~last_grant_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b0;
      owner_q      <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_rdata     <= '0;
      d_rdata      <= '0;
      if_ready     <= 1'b0;
      d_ready      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (if_req || d_req) begin
            owner_q      <= grant_d;
            last_grant_q <= grant_d;
            if (grant_d) begin
              mem_addr  <= d_addr & WordMask;
              mem_we    <= d_we;
              mem_wdata <= d_wdata;
            end else begin
              mem_addr  <= if_addr & WordMask;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
            end
            mem_en  <= 1'b1;
            busy    <= 1'b1;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          cnt_q   <= CntLoad;
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            // mem_we still holds the granted access's direction here.
            if (!owner_q) begin
              if_rdata <= mem_rdata;
              if_ready <= 1'b1;
            end else begin
              if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
              d_ready <= 1'b1;
            end
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDone: begin
          // Requests are deliberately not sampled here.
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;

  // LATENCY=2 instance (main)
  logic [31:0] if_rdata_l2, d_rdata_l2, mem_addr_l2, mem_wdata_l2, mem_rdata_l2;
  logic        if_ready_l2, d_ready_l2, mem_en_l2, mem_we_l2, busy_l2;
  // LATENCY=1 instance
  logic [31:0] if_rdata_l1, d_rdata_l1, mem_addr_l1, mem_wdata_l1, mem_rdata_l1;
  logic        if_ready_l1, d_ready_l1, mem_en_l1, mem_we_l1, busy_l1;
  // LATENCY=15 instance
  logic [31:0] if_rdata_l15, d_rdata_l15, mem_addr_l15, mem_wdata_l15, mem_rdata_l15;
  logic        if_ready_l15, d_ready_l15, mem_en_l15, mem_we_l15, busy_l15;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LATENCY(2), .ADDR_W(32), .DATA_W(32)) u_l2 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_l2), .if_ready(if_ready_l2),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata_l2), .d_ready(d_ready_l2),
    .mem_en(mem_en_l2), .mem_we(mem_we_l2), .mem_addr(mem_addr_l2),
    .mem_wdata(mem_wdata_l2), .mem_rdata(mem_rdata_l2), .busy(busy_l2)
  );

  mem_port_arbiter #(.LATENCY(1), .ADDR_W(32), .DATA_W(32)) u_l1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_l1), .if_ready(if_ready_l1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata_l1), .d_ready(d_ready_l1),
    .mem_en(mem_en_l1), .mem_we(mem_we_l1), .mem_addr(mem_addr_l1),
    .mem_wdata(mem_wdata_l1), .mem_rdata(mem_rdata_l1), .busy(busy_l1)
  );

  mem_port_arbiter #(.LATENCY(15), .ADDR_W(32), .DATA_W(32)) u_l15 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_l15), .if_ready(if_ready_l15),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata_l15), .d_ready(d_ready_l15),
    .mem_en(mem_en_l15), .mem_we(mem_we_l15), .mem_addr(mem_addr_l15),
    .mem_wdata(mem_wdata_l15), .mem_rdata(mem_rdata_l15), .busy(busy_l15)
  );

  // Fixed-latency memory models: the read value appears only in the cycle that
  // is exactly LATENCY cycles after mem_en; every other cycle carries its
  // complement so a mistimed capture is visible.
  int          lat2 = 0, lat1 = 0, lat15 = 0;
  logic [31:0] rd2 = 32'h0, rd1 = 32'h0, rd15 = 32'h0;

  always @(posedge clk) begin
    if (mem_en_l2) lat2 <= 2;
    else if (lat2 != 0) lat2 <= lat2 - 1;
    if (mem_en_l1) lat1 <= 1;
    else if (lat1 != 0) lat1 <= lat1 - 1;
    if (mem_en_l15) lat15 <= 15;
    else if (lat15 != 0) lat15 <= lat15 - 1;
  end

  assign mem_rdata_l2  = (lat2 == 1)  ? rd2  : ~rd2;
  assign mem_rdata_l1  = (lat1 == 1)  ? rd1  : ~rd1;
  assign mem_rdata_l15 = (lat15 == 1) ? rd15 : ~rd15;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] rd;
    logic        own_d;
    logic [31:0] e_addr;
    logic        e_we;
    logic [31:0] e_wdata;
    logic [31:0] e_if_rdata;
    logic [31:0] e_d_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_en"},    {31'b0, mem_en_l2},   32'h0);
    chk({tag, ".mem_we"},    {31'b0, mem_we_l2},   32'h0);
    chk({tag, ".mem_addr"},  mem_addr_l2,          32'h0);
    chk({tag, ".mem_wdata"}, mem_wdata_l2,         32'h0);
    chk({tag, ".if_rdata"},  if_rdata_l2,          32'h0);
    chk({tag, ".d_rdata"},   d_rdata_l2,           32'h0);
    chk({tag, ".if_ready"},  {31'b0, if_ready_l2}, 32'h0);
    chk({tag, ".d_ready"},   {31'b0, d_ready_l2},  32'h0);
    chk({tag, ".busy"},      {31'b0, busy_l2},     32'h0);
  endtask

  initial begin
    int f1, f15, en15;
    logic [31:0] r1, r15;

    // if_req, if_addr, d_req, d_we, d_addr, d_wdata, rd,
    // own_d, e_addr, e_we, e_wdata, e_if_rdata, e_d_rdata
    vecs[0] = '{1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF,
                1'b0, 32'h0000_0010, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 32'hCAFE_F00D,
                1'b1, 32'h0000_0040, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0047, 32'h0000_0055, 32'h0BAD_F00D,
                1'b1, 32'h0000_0044, 1'b0, 32'h0000_0055, 32'hDEAD_BEEF, 32'h0BAD_F00D};
    vecs[3] = '{1'b1, 32'h0000_0102, 1'b1, 1'b1, 32'h0000_0203, 32'h0000_0077, 32'h1111_2222,
                1'b0, 32'h0000_0100, 1'b0, 32'h0, 32'h1111_2222, 32'h0BAD_F00D};
    vecs[4] = '{1'b1, 32'h0000_0300, 1'b1, 1'b0, 32'h0000_0404, 32'h0000_0099, 32'h3333_4444,
                1'b1, 32'h0000_0404, 1'b0, 32'h0000_0099, 32'h1111_2222, 32'h3333_4444};
    vecs[5] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 32'h0, 32'h5A5A_5A5A,
                1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h5A5A_5A5A, 32'h3333_4444};
    vecs[6] = '{1'b1, 32'h0000_0020, 1'b1, 1'b1, 32'h0000_0008, 32'h0000_ABCD, 32'hEEEE_0000,
                1'b1, 32'h0000_0008, 1'b1, 32'h0000_ABCD, 32'h5A5A_5A5A, 32'h3333_4444};

    reset = 1'b1; if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    step();
    step();
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    // Table-driven single transactions; each request is held through its
    // ready cycle and then dropped.
    for (int i = 0; i < 7; i++) begin
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      d_req = vecs[i].d_req; d_we = vecs[i].d_we;
      d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
      rd2 = vecs[i].rd;
      step(); // cycle 1
      chk($sformatf("v%0d.c1.mem_en", i), {31'b0, mem_en_l2}, 32'h1);
      chk($sformatf("v%0d.c1.mem_we", i), {31'b0, mem_we_l2}, {31'b0, vecs[i].e_we});
      chk($sformatf("v%0d.c1.mem_addr", i), mem_addr_l2, vecs[i].e_addr);
      chk($sformatf("v%0d.c1.mem_wdata", i), mem_wdata_l2, vecs[i].e_wdata);
      chk($sformatf("v%0d.c1.busy", i), {31'b0, busy_l2}, 32'h1);
      chk($sformatf("v%0d.c1.readys", i), {30'b0, if_ready_l2, d_ready_l2}, 32'h0);
      step(); // cycle 2
      chk($sformatf("v%0d.c2.mem_en", i), {31'b0, mem_en_l2}, 32'h0);
      chk($sformatf("v%0d.c2.busy", i), {31'b0, busy_l2}, 32'h1);
      step(); // cycle 3
      chk($sformatf("v%0d.c3.readys", i), {30'b0, if_ready_l2, d_ready_l2}, 32'h0);
      step(); // cycle 4: ready
      chk($sformatf("v%0d.c4.if_ready", i), {31'b0, if_ready_l2}, {31'b0, ~vecs[i].own_d});
      chk($sformatf("v%0d.c4.d_ready", i), {31'b0, d_ready_l2}, {31'b0, vecs[i].own_d});
      chk($sformatf("v%0d.c4.if_rdata", i), if_rdata_l2, vecs[i].e_if_rdata);
      chk($sformatf("v%0d.c4.d_rdata", i), d_rdata_l2, vecs[i].e_d_rdata);
      chk($sformatf("v%0d.c4.busy", i), {31'b0, busy_l2}, 32'h1);
      if_req = 1'b0; d_req = 1'b0;
      step(); // cycle 5
      chk($sformatf("v%0d.c5.readys", i), {30'b0, if_ready_l2, d_ready_l2}, 32'h0);
      chk($sformatf("v%0d.c5.busy", i), {31'b0, busy_l2}, 32'h0);
      chk($sformatf("v%0d.c5.mem_addr_held", i), mem_addr_l2, vecs[i].e_addr);
      step(); // cycle 6: the held request must not have been re-issued
      chk($sformatf("v%0d.c6.mem_en", i), {31'b0, mem_en_l2}, 32'h0);
      chk($sformatf("v%0d.c6.busy", i), {31'b0, busy_l2}, 32'h0);
    end

    // Reset in the WAIT cycle of a fetch read (last grant was data here).
    if_req = 1'b1; if_addr = 32'h0000_0500; rd2 = 32'h6666_7777;
    step(); // cycle 1 ISSUE
    step(); // cycle 2 WAIT
    reset = 1'b1; if_req = 1'b0;
    step(); // cycle 3
    chk_all_zero("rst_mid");
    reset = 1'b0;
    for (int c = 4; c <= 6; c++) begin
      step();
      chk($sformatf("rst_mid.c%0d.readys", c), {30'b0, if_ready_l2, d_ready_l2}, 32'h0);
      chk($sformatf("rst_mid.c%0d.busy", c), {31'b0, busy_l2}, 32'h0);
    end

    // Back-to-back contention right after reset: expect data, fetch, data.
    if_req = 1'b1; if_addr = 32'h0000_1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000; d_wdata = 32'h0;
    rd2 = 32'h7777_8888;
    for (int c = 1; c <= 16; c++) begin
      step();
      chk($sformatf("cont.c%0d.mem_en", c), {31'b0, mem_en_l2},
          {31'b0, (c == 1 || c == 6 || c == 11)});
      if (c == 1 || c == 11) chk($sformatf("cont.c%0d.mem_addr", c), mem_addr_l2, 32'h0000_2000);
      if (c == 6) chk("cont.c6.mem_addr", mem_addr_l2, 32'h0000_1000);
      chk($sformatf("cont.c%0d.if_ready", c), {31'b0, if_ready_l2}, {31'b0, (c == 9)});
      chk($sformatf("cont.c%0d.d_ready", c), {31'b0, d_ready_l2}, {31'b0, (c == 4 || c == 14)});
      if (c == 4) chk("cont.c4.d_rdata", d_rdata_l2, 32'h7777_8888);
      if (c == 9) chk("cont.c9.if_rdata", if_rdata_l2, 32'h7777_8888);
      if (c == 12) begin
        if_req = 1'b0; d_req = 1'b0;
      end
    end

    // LATENCY=1 and LATENCY=15 corner cases.
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    rd1 = 32'h1111_0001; rd15 = 32'hF0F0_000F;
    if_req = 1'b1; if_addr = 32'h0000_0060;
    f1 = -1; f15 = -1; en15 = 0; r1 = 32'h0; r15 = 32'h0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (if_ready_l1 && f1 < 0) begin
        f1 = c; r1 = if_rdata_l1;
      end
      if (if_ready_l15 && f15 < 0) begin
        f15 = c; r15 = if_rdata_l15;
      end
      if (mem_en_l15) en15++;
      if (c == 18) begin
        chk("lat15.c18.if_ready", {31'b0, if_ready_l15}, 32'h0);
        if_req = 1'b0;
      end
    end
    chk("lat1.ready_cycle", f1, 32'd3);
    chk("lat1.if_rdata", r1, 32'h1111_0001);
    chk("lat15.ready_cycle", f15, 32'd17);
    chk("lat15.if_rdata", r15, 32'hF0F0_000F);
    chk("lat15.mem_en_count", en15, 32'd1);
    chk("lat15.busy_after", {31'b0, busy_l15}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
